stream_concatenator: RTL and testbench
======================================

# stream_concatenator

Parametrised successor to the three-input byte concatenator. It merges `NUM_CH` input streams into one `OUT_W`-bit output stream, draining each channel in strict order 0..NUM_CH-1 until that channel's `last` beat, then wrapping back to channel 0 for the next frame. Each input beat carries up to `LANES` output-width lanes with an explicit lane count, so byte-wide and wide-word sources share one port type. It sits between framed segment producers (header, payload, trailer) and a byte-serial transmit path.

## Interface
- `NUM_CH`, 3, number of input channels (≥2).
- `OUT_W`, 8, output width in bits; also the lane width of every input beat.
- `LANES`, 12, maximum lanes per input beat (≥1).
- `CNT_W`, $clog2(LANES+1), derived; width of each lane-count field.
- `CH_W`, $clog2(NUM_CH) (min 1), derived.
- `i_clock` in 1: single clock, rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_in_data` in NUM_CH*LANES*OUT_W: channel c at slice c; lane 0 in the LSBs of the slice, sent first.
- `i_in_count` in NUM_CH*CNT_W: number of valid lanes in the beat, channel c at slice c.
- `i_in_last` in NUM_CH: marks the final beat of channel c's segment.
- `i_in_valid` in NUM_CH: per-channel beat valid.
- `o_in_ready` in NUM_CH: per-channel ready, one-hot or zero.
- `o_out_data` out OUT_W: output lane.
- `o_out_valid` out 1, `i_out_ready` in 1: output handshake.
- `o_out_last` out 1: high on the final lane of channel NUM_CH-1's last beat, which is the end of the frame.
- `o_chan` out CH_W: channel currently being drained.

## Operation
- Registers: holding register (LANES*OUT_W), lane index `idx`, captured count `cnt`, captured last flag `lst`, current channel `cur`, and state.
- States:
  - LOAD: holding register empty. `o_in_ready[cur]`=1; all other bits are 0.
  - SHIFT: holding register contains lanes to send.
- LOAD, on `i_in_valid[cur]`:
  - Capture data, `lst`, and `cnt`=min(count, LANES). Set `idx`=0.
  - If the clamped count is ≥1, go to SHIFT.
  - If the count is 0, no lanes are emitted. If last is set, advance `cur`. Stay in LOAD.
- SHIFT:
  - `o_out_valid`=1 and `o_out_data`=lane[`idx`].
  - On `o_out_valid && i_out_ready` with `idx`<`cnt`-1: increment `idx`.
  - On `o_out_valid && i_out_ready` with `idx`==`cnt`-1: go to LOAD. If `lst` is set, advance `cur`.
- Advance rule: `cur` becomes `cur`+1, or wraps to 0 when `cur`==NUM_CH-1.
- `o_out_last` = SHIFT && `idx`==`cnt`-1 && `lst` && `cur`==NUM_CH-1.
- Valid on non-current channels is ignored and never acknowledged. Data on those channels is held by their sources.
- `o_out_valid`, `o_out_data` and `o_out_last` are stable while `o_out_valid && !i_out_ready`.
- `o_chan` = `cur`.

## Timing
- Reset (async assert, i_reset_n=0):
  - State LOAD, `cur`=0, `idx`=0.
  - `o_out_valid`=0, `o_out_data`=0, `o_out_last`=0, `o_chan`=0.
  - `o_in_ready`=1 on bit 0 only.
  - Deassertion is used synchronously: it is sampled at the first rising edge.
- Input handshake: a beat accepted at edge k gives its first lane valid in cycle k+1. `o_in_ready` is registered-state derived with no combinational path from `i_out_ready`.
- Throughput: a beat of n lanes occupies n+1 cycles under full output ready, because LOAD adds one bubble. A byte stream (count=1) runs at 1/2 rate.
- Count-0 beat: consumes one cycle in LOAD and produces no output.
- Reset mid-frame: partial frame is discarded and the holding register is cleared. The next accepted beat comes from channel 0.
- Backpressure: `idx` does not change without a handshake. Stall duration is unbounded.

## Test plan
- Idle: all valid=0, `i_out_ready`=1 for 1000 cycles → zero output handshakes, `o_in_ready`=3'b001.
- Legacy frame (NUM_CH=3, LANES=12):
  - Stimulus: ch0 sends 144 beats with count=1 and data 0..143, last on the 144th. ch1 sends 1 beat with count=12 and data 144..155, last. ch2 sends 11 beats with count=12 and data 156..287, last on the 11th. All channels present valid simultaneously.
  - Response: 288 outputs equal to n&8'hFF in order. `o_out_last` is high only on output 287.
  - A second identical frame follows immediately and starts at ch0.
- Backpressure: run the legacy frame with `i_out_ready` toggling 1,0,0,1 pseudo-randomly → identical data sequence, no drops or duplicates, and outputs stable across stalls.
- Edge counts:
  - A ch1 beat with count=0 and last=1 → no lanes emitted; `o_chan` goes from 1 to 2 one cycle later.
  - A beat with count=15 (CNT_W=4) → exactly 12 lanes emitted.
- Async reset: pull `i_reset_n` low mid-way through ch2 beat 5, not on a clock edge → outputs go to 0 immediately. After release, a fresh legacy frame is output correctly from 0.
- Channel isolation: hold `i_in_valid[2]`=1 during ch0's segment → `o_in_ready[2]`=0 until `o_chan`=2; ch2 data appears only after ch1's last lane.

Source files
------------

// File: rtl/stream_concatenator.sv
// stream_concatenator
// Merges NUM_CH framed input streams into one OUT_W-bit lane stream. Channels
// are drained strictly in order 0..NUM_CH-1, each up to its last beat, after
// which the next channel is selected; after channel NUM_CH-1 the frame wraps
// back to channel 0. Every input beat carries up to LANES lanes plus a lane
// count, so byte sources and wide-word sources share one port format.
module stream_concatenator #(
    parameter int NUM_CH = 3,
    parameter int OUT_W  = 8,
    parameter int LANES  = 12,
    parameter int CNT_W  = $clog2(LANES + 1),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [NUM_CH*LANES*OUT_W-1:0] i_in_data,
    input  logic [NUM_CH*CNT_W-1:0]       i_in_count,
    input  logic [NUM_CH-1:0]             i_in_last,
    input  logic [NUM_CH-1:0]             i_in_valid,
    output logic [NUM_CH-1:0]             o_in_ready,
    output logic [OUT_W-1:0]              o_out_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_out_last,
    output logic [CH_W-1:0]               o_chan
);

    localparam int SLICE_W = LANES * OUT_W;
    localparam int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Control state
    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic              lst;
    logic [CH_W-1:0]   cur;

    // Holding register, one entry per lane, lane 0 sent first
    logic [OUT_W-1:0]  hold [LANES];

    // Registered outputs
    logic [NUM_CH-1:0] in_ready_r;
    logic [OUT_W-1:0]  out_data_r;
    logic              out_valid_r;
    logic              out_last_r;

    // Decode of the currently selected input channel
    logic [SLICE_W-1:0] sel_data;
    logic [CNT_W-1:0]   sel_count;
    logic               sel_last;
    logic               sel_valid;
    logic [CNT_W-1:0]   sel_cnt;

    // Derived control terms
    logic [CH_W-1:0]    nxt_cur;
    logic               cur_is_last;
    logic [IDX_W-1:0]   idx_inc;
    logic               at_end;
    logic               inc_is_end;

    // Lane counts above LANES are treated as a full beat.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > LANES_C) ? LANES_C : n;
    endfunction

    // One-hot ready vector for a given channel.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c)) begin
                r[c] = 1'b1;
            end
        end
        return r;
    endfunction

    // Select the fields of the channel currently being drained.
    always_comb begin
        sel_data  = '0;
        sel_count = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur == CH_W'(c)) begin
                sel_data  = i_in_data[c*SLICE_W +: SLICE_W];
                sel_count = i_in_count[c*CNT_W +: CNT_W];
                sel_last  = i_in_last[c];
                sel_valid = i_in_valid[c];
            end
        end
        sel_cnt = clamp_count(sel_count);
    end

    // Channel advance and lane position terms.
    always_comb begin
        cur_is_last = (cur == LAST_CH);
        nxt_cur     = cur_is_last ? '0 : cur + CH_W'(1);
        idx_inc     = idx + IDX_W'(1);
        at_end      = (CNT_W'(idx) == cnt - ONE_C);
        inc_is_end  = (CNT_W'(idx_inc) == cnt - ONE_C);
    end

    // Load/shift state machine with registered handshake and output signals.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_LOAD;
            cur         <= '0;
            idx         <= '0;
            cnt         <= '0;
            lst         <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                hold[l] <= '0;
            end
            in_ready_r  <= ch_onehot('0);
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (sel_valid) begin
                        for (int l = 0; l < LANES; l++) begin
                            hold[l] <= sel_data[l*OUT_W +: OUT_W];
                        end
                        cnt <= sel_cnt;
                        lst <= sel_last;
                        idx <= '0;
                        if (sel_cnt != '0) begin
                            state       <= S_SHIFT;
                            in_ready_r  <= '0;
                            out_valid_r <= 1'b1;
                            out_data_r  <= sel_data[OUT_W-1:0];
                            out_last_r  <= (sel_cnt == ONE_C) && sel_last && cur_is_last;
                        end else if (sel_last) begin
                            // Empty closing beat: skip straight to the next channel.
                            cur        <= nxt_cur;
                            in_ready_r <= ch_onehot(nxt_cur);
                        end
                    end
                end
                S_SHIFT: begin
                    if (i_out_ready) begin
                        if (!at_end) begin
                            idx        <= idx_inc;
                            out_data_r <= hold[idx_inc];
                            out_last_r <= inc_is_end && lst && cur_is_last;
                        end else begin
                            state       <= S_LOAD;
                            out_valid_r <= 1'b0;
                            out_data_r  <= '0;
                            out_last_r  <= 1'b0;
                            if (lst) begin
                                cur        <= nxt_cur;
                                in_ready_r <= ch_onehot(nxt_cur);
                            end else begin
                                in_ready_r <= ch_onehot(cur);
                            end
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    assign o_in_ready  = in_ready_r;
    assign o_out_data  = out_data_r;
    assign o_out_valid = out_valid_r;
    assign o_out_last  = out_last_r;
    assign o_chan      = cur;

endmodule

// File: tb/tb_stream_concatenator.sv
// Testbench for stream_concatenator: randomized-data frames driven from
// per-channel beat queues, checked against an expected lane queue built by
// concatenating each frame's channel segments.
module tb_stream_concatenator;

    localparam int NUM_CH  = 3;
    localparam int OUT_W   = 8;
    localparam int LANES   = 12;
    localparam int CNT_W   = 4;
    localparam int CH_W    = 2;
    localparam int SLICE_W = LANES * OUT_W;

    typedef struct {
        logic [SLICE_W-1:0] data;
        int                 count;
        logic               last;
    } beat_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
        int               chan;
    } lane_t;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_CH*SLICE_W-1:0]     in_data;
    logic [NUM_CH*CNT_W-1:0]       in_count;
    logic [NUM_CH-1:0]             in_last;
    logic [NUM_CH-1:0]             in_valid;
    logic [NUM_CH-1:0]             in_ready;
    logic [OUT_W-1:0]              out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic [CH_W-1:0]               chan;

    always #5 clk = ~clk;

    stream_concatenator #(
        .NUM_CH (NUM_CH),
        .OUT_W  (OUT_W),
        .LANES  (LANES)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_in_data   (in_data),
        .i_in_count  (in_count),
        .i_in_last   (in_last),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_last  (out_last),
        .o_chan      (chan)
    );

    beat_t       src_q [NUM_CH][$];
    beat_t       frm   [NUM_CH][$];
    lane_t       exp_q [$];

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    logic [NUM_CH-1:0] acc = '0;
    logic        stall_pend = 1'b0;
    logic [OUT_W-1:0] stall_data = '0;
    logic        stall_last = 1'b0;
    logic        zero_pend = 1'b0;
    int          zero_chan = 0;
    logic        bp_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [SLICE_W-1:0] rand_slice();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit src_pending();
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_q[c].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Move the frame under construction into the sources and expected stream.
    task automatic commit_frame();
        lane_t e;
        int    n;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < frm[c].size(); k++) begin
                n = (frm[c][k].count > LANES) ? LANES : frm[c][k].count;
                for (int l = 0; l < n; l++) begin
                    e.data = frm[c][k].data[l*OUT_W +: OUT_W];
                    e.last = (c == NUM_CH - 1) && frm[c][k].last && (l == n - 1);
                    e.chan = c;
                    exp_q.push_back(e);
                end
                src_q[c].push_back(frm[c][k]);
            end
            frm[c].delete();
        end
    endtask

    task automatic build_legacy();
        beat_t b;
        for (int i = 0; i < 144; i++) begin
            b.data      = rand_slice();
            b.data[7:0] = 8'(i);
            b.count     = 1;
            b.last      = (i == 143);
            frm[0].push_back(b);
        end
        b.data = rand_slice();
        for (int l = 0; l < LANES; l++) b.data[l*OUT_W +: OUT_W] = 8'(144 + l);
        b.count = 12;
        b.last  = 1'b1;
        frm[1].push_back(b);
        for (int k = 0; k < 11; k++) begin
            for (int l = 0; l < LANES; l++) b.data[l*OUT_W +: OUT_W] = 8'(156 + k*12 + l);
            b.count = 12;
            b.last  = (k == 10);
            frm[2].push_back(b);
        end
        commit_frame();
    endtask

    task automatic build_random();
        beat_t b;
        int    nb;
        for (int c = 0; c < NUM_CH; c++) begin
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                b.data  = rand_slice();
                b.count = $urandom_range(0, 15);
                b.last  = (k == nb - 1);
                frm[c].push_back(b);
            end
        end
        commit_frame();
    endtask

    task automatic build_edge();
        beat_t b;
        b.data = rand_slice(); b.count = 2;  b.last = 1'b1; frm[0].push_back(b);
        b.data = rand_slice(); b.count = 3;  b.last = 1'b0; frm[1].push_back(b);
        b.data = rand_slice(); b.count = 0;  b.last = 1'b1; frm[1].push_back(b);
        b.data = rand_slice(); b.count = 15; b.last = 1'b1; frm[2].push_back(b);
        commit_frame();
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_last  = '0;
        in_count = '0;
        in_data  = '0;
    endtask

    // One clock cycle: retire accepted beats, check outputs, drive next inputs.
    task automatic step();
        beat_t b;
        lane_t e;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
        end
        if (zero_pend) begin
            chk("zero_beat_chan", 64'(chan), 64'(zero_chan));
            zero_pend = 1'b0;
        end
        if (stall_pend) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(stall_data));
            chk("stall_last", 64'(out_last), 64'(stall_last));
        end
        chk("ready_cur_only", 64'(in_ready & ~(NUM_CH'(1) << chan)), 64'(0));
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_q[c].size() != 0) begin
                b = src_q[c][0];
                in_valid[c]                   = 1'b1;
                in_data[c*SLICE_W +: SLICE_W] = b.data;
                in_count[c*CNT_W +: CNT_W]    = CNT_W'(b.count);
                in_last[c]                    = b.last;
            end else begin
                in_valid[c]                   = 1'b0;
                in_data[c*SLICE_W +: SLICE_W] = '0;
                in_count[c*CNT_W +: CNT_W]    = '0;
                in_last[c]                    = 1'b0;
            end
        end
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            acc[c] = in_valid[c] & in_ready[c];
            if (acc[c] && src_q[c][0].count == 0) begin
                zero_pend = 1'b1;
                zero_chan = src_q[c][0].last ? (c + 1) % NUM_CH : c;
            end
        end
        if (out_valid === 1'b1) begin
            if (out_ready) begin
                chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("out_chan", 64'(chan), 64'(e.chan));
                end
                n_out++;
            end
        end else begin
            chk("last_without_valid", 64'(out_last), 64'(0));
        end
        stall_pend = (out_valid === 1'b1) && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
    endtask

    task automatic run_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || src_pending()) && k < budget) begin
            step();
            k++;
        end
        chk("drain_complete", 64'(exp_q.size()), 64'(0));
        repeat (4) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_chan", 64'(chan), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(3'b001));
        rst_n = 1'b1;

        // Idle: nothing queued, sink always ready
        n0 = n_out;
        repeat (1000) step();
        chk("idle_outputs", 64'(n_out - n0), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(3'b001));

        // Two back-to-back legacy frames
        n0 = n_out;
        build_legacy();
        build_legacy();
        run_drain(3000);
        chk("legacy_count", 64'(n_out - n0), 64'(576));
        chk("legacy_end_chan", 64'(chan), 64'(0));

        // Legacy frame under random backpressure
        bp_mode = 1'b1;
        n0 = n_out;
        build_legacy();
        run_drain(6000);
        chk("bp_count", 64'(n_out - n0), 64'(288));
        bp_mode = 1'b0;

        // Empty closing beat and oversize count
        n0 = n_out;
        build_edge();
        run_drain(200);
        chk("edge_count", 64'(n_out - n0), 64'(17));

        // Random frames, random backpressure
        bp_mode = 1'b1;
        for (int f = 0; f < 6; f++) build_random();
        run_drain(4000);
        bp_mode = 1'b0;

        // Async reset in the middle of channel 2 beat 5
        n0 = n_out;
        build_legacy();
        for (int k = 0; k < 2000 && (n_out - n0) < 209; k++) step();
        chk("reached_reset_point", 64'(n_out - n0), 64'(209));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_out_data", 64'(out_data), 64'(0));
        chk("arst_out_last", 64'(out_last), 64'(0));
        chk("arst_chan", 64'(chan), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(3'b001));
        for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
        exp_q.delete();
        acc        = '0;
        stall_pend = 1'b0;
        zero_pend  = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n0 = n_out;
        build_legacy();
        run_drain(3000);
        chk("post_reset_count", 64'(n_out - n0), 64'(288));

        // Channel isolation: ch2 valid throughout a long ch0 segment
        n0 = n_out;
        build_legacy();
        for (int k = 0; k < 100; k++) begin
            step();
            if (chan != 2'd2) chk("iso_ready2", 64'(in_ready[2]), 64'(0));
        end
        run_drain(3000);
        chk("iso_count", 64'(n_out - n0), 64'(288));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
